// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: scan request, blackbox stimulus/response and captured-table signals
interface truth_table_scanner_if #(parameter int N_IN = 3);
  logic start;
  logic u_in;
  logic [N_IN-1:0] vec;
  logic busy;
  logic done;
  logic [2**N_IN-1:0] table_out;
  logic valid;
  modport master(output start, u_in, input vec, busy, done, table_out, valid);
  modport slave(input start, u_in, output vec, busy, done, table_out, valid);
endinterface

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps every input vector into a blackbox and captures its output as a truth table
module truth_table_scanner #(
  parameter int N_IN = 3,
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst_n,
  truth_table_scanner_if.slave bus
);
  localparam int W = 2**N_IN;
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d, vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] work_q, work_d, table_q, table_d;
  logic busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      vec_q <= '0;
      cnt_q <= '0;
      work_q <= '0;
      table_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      vec_q <= vec_d;
      cnt_q <= cnt_d;
      work_q <= work_d;
      table_q <= table_d;
      busy_q <= busy_d;
      done_q <= done_d;
      valid_q <= valid_d;
    end
  end
  // table_out only updates at scan start (cleared) and at DONE, so IDLE keeps the last result
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    vec_d = vec_q;
    cnt_d = cnt_q;
    work_d = work_q;
    table_d = table_q;
    busy_d = busy_q;
    done_d = 1'b0;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_SETTLE;
        idx_d = '0;
        vec_d = '0;
        cnt_d = '0;
        work_d = '0;
        table_d = '0;
        busy_d = 1'b1;
        valid_d = 1'b0;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(SETTLE - 1) ? S_SAMPLE : S_SETTLE;
      end
      S_SAMPLE: begin
        work_d[idx_q] = bus.u_in;
        if (idx_q == N_IN'(W - 1)) state_d = S_DONE;
        else begin
          idx_d = idx_q + 1'b1;
          vec_d = idx_q + 1'b1;
          cnt_d = '0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        table_d = work_q;
        valid_d = 1'b1;
        busy_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.vec = vec_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.table_out = table_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: random and directed scans checked against a truth-table model of the blackbox
module tb_truth_table_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tbl = 8'h00;
  logic noise = 1'b0;
  logic tog = 1'b0;
  int ph = 2;
  int errs = 0;
  int checks = 0;
  truth_table_scanner_if #(.N_IN(3)) bus();
  truth_table_scanner #(.N_IN(3), .SETTLE(2)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(negedge clk) tog <= ~tog;
  assign bus.u_in = (noise && ph != 2) ? tog : tbl[bus.vec];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [7:0] model(input int m);
    logic [7:0] t;
    for (int k = 0; k < 8; k++) begin
      logic q, i, f;
      q = k[2]; i = k[1]; f = k[0];
      t[k] = m == 0 ? ((q & i) | f) : m == 1 ? (q ^ i ^ f) : m == 2 ? 1'b0 : 1'b1;
    end
    return t;
  endfunction
  task automatic scan(input logic [7:0] f, input bit nz, input bit repulse, input bit do_rst, input bit hold);
    bit vec_ok = 1'b1;
    bit rst_hit = 1'b0;
    int dcnt = 0;
    int first = -1;
    @(negedge clk);
    tbl = f;
    noise = nz;
    ph = 2;
    bus.start = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 30; j++) begin
      if (j > 0) @(posedge clk);
      @(negedge clk);
      ph = j % 3;
      bus.start = (repulse && j == 9) || hold;
      if (j == 0) chk("start_clear", {bus.busy, bus.valid, bus.table_out}, {1'b1, 1'b0, 8'h00});
      if (!rst_hit && j < 24 && bus.vec != 3'(j / 3)) vec_ok = 1'b0;
      if (bus.done) begin
        dcnt++;
        if (first < 0) first = j;
      end
      if (hold && j == 25) chk("gap_idle", {bus.busy, bus.done}, 2'b01);
      if (hold && j == 26) chk("b2b_accept", {bus.busy, bus.valid, bus.table_out}, {1'b1, 1'b0, 8'h00});
      if (do_rst && j == 15) begin
        chk("vec_before_rst", bus.vec, 5);
        #1 rst_n = 1'b0;
        #1 chk("async_rst", {bus.vec, bus.busy, bus.done, bus.valid, bus.table_out}, 0);
        #1 rst_n = 1'b1;
        rst_hit = 1'b1;
      end
      if (hold && j == 26) break;
    end
    ph = 2;
    bus.start = 1'b0;
    chk("vec_seq", vec_ok, 1);
    if (do_rst) chk("no_done_after_rst", dcnt, 0);
    else begin
      chk("done_latency", first, 25);
      chk("done_count", dcnt, 1);
      if (!hold) chk("table", bus.table_out, f);
      if (!hold) chk("valid_busy", {bus.valid, bus.busy}, 2'b10);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_state", {bus.vec, bus.busy, bus.done, bus.valid, bus.table_out}, 0);
    scan(model(0), 1'b0, 1'b0, 1'b0, 1'b0);
    scan(model(1), 1'b0, 1'b1, 1'b0, 1'b0);
    scan(model(2), 1'b0, 1'b0, 1'b0, 1'b0);
    scan(model(3), 1'b0, 1'b0, 1'b0, 1'b0);
    scan(model(1), 1'b0, 1'b0, 1'b1, 1'b0);
    scan(model(0), 1'b0, 1'b0, 1'b0, 1'b0);
    scan(model(0), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) scan(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    scan(model(1), 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    scan(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
